// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: forwarding select encoding and scoreboard latency constants.
package cpu_types_pkg;

    localparam int unsigned DEF_NFWD  = 2;
    localparam int unsigned DEF_LAT_W = 3;
    localparam int unsigned DEF_SEL_W = $clog2(DEF_NFWD + 1);

    localparam int unsigned FWD_REGFILE = 0;

    typedef logic [DEF_SEL_W-1:0] fwdsel_t;

    // Size-cast to any latency width this yields all-ones: the variable-latency marker.
    localparam int LAT_VAR = -1;

endpackage

// File: rtl/forward_scoreboard_if.sv
// Signal bundle between pipeline control and the forwarding/scoreboard unit.
interface forward_scoreboard_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned LAT_W = 3,
    parameter int unsigned SEL_W = $clog2(NFWD + 1)
);
    logic [NSRC*REG_W-1:0] src_addr;
    logic [NFWD-1:0]       fwd_regwr;
    logic [NFWD*REG_W-1:0] fwd_wsel;
    logic                  issue_valid;
    logic [REG_W-1:0]      issue_rd;
    logic [LAT_W-1:0]      issue_lat;
    logic                  done_valid;
    logic [REG_W-1:0]      done_rd;
    logic                  flush;
    logic [NSRC*SEL_W-1:0] forward_sel;
    logic                  stall;
    logic                  issue_ack;

    modport master (
        output src_addr, fwd_regwr, fwd_wsel, issue_valid, issue_rd, issue_lat,
               done_valid, done_rd, flush,
        input  forward_sel, stall, issue_ack
    );

    modport slave (
        input  src_addr, fwd_regwr, fwd_wsel, issue_valid, issue_rd, issue_lat,
               done_valid, done_rd, flush,
        output forward_sel, stall, issue_ack
    );
endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-write countdown with flush/load/done/hold/decrement priority.
module sb_entry
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT_W = DEF_LAT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             load,
    input  logic             done,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);
    localparam logic [LAT_W-1:0] CNT_VAR = LAT_W'(LAT_VAR);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)                cnt_d = '0;
        else if (load)            cnt_d = load_val;
        else if (done)            cnt_d = '0;
        else if (cnt_q == CNT_VAR) cnt_d = cnt_q;
        else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/forward_scoreboard.sv
// Operand forwarding selects and pending-write scoreboard stall at the decode/execute boundary.
// Optional saturating stall-cycle counter: define FWD_STALL_CNT_EN.
module forward_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NFWD  = DEF_NFWD,
    parameter int unsigned LAT_W = DEF_LAT_W,
    parameter int unsigned SEL_W = $clog2(NFWD + 1)
) (
    input logic CLK,
    input logic RST,
    forward_scoreboard_if.slave bus
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int unsigned NREG = 2 ** REG_W;
    localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT_VAR);

    logic [LAT_W-1:0] cnt [NREG];
    logic [LAT_W-1:0] load_val;
    logic             stall;
    logic             issue_ack;

    // Youngest matching stage wins; each operand resolved on its own.
    always_comb begin
        logic [REG_W-1:0] src;
        logic [SEL_W-1:0] sel;
        logic             hit;
        src = '0;
        sel = '0;
        hit = 1'b0;
        bus.forward_sel = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src = bus.src_addr[i*REG_W +: REG_W];
            sel = SEL_W'(FWD_REGFILE);
            hit = 1'b0;
            for (int unsigned k = 0; k < NFWD; k++) begin
                if (!hit && src != '0 && bus.fwd_regwr[k] &&
                    bus.fwd_wsel[k*REG_W +: REG_W] == src) begin
                    sel = SEL_W'(k + 1);
                    hit = 1'b1;
                end
            end
            bus.forward_sel[i*SEL_W +: SEL_W] = sel;
        end
    end

    always_comb begin
        logic [REG_W-1:0] src;
        src   = '0;
        stall = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src = bus.src_addr[i*REG_W +: REG_W];
            if (src != '0 && cnt[src] != '0) stall = 1'b1;
        end
    end

    assign issue_ack     = bus.issue_valid && !stall;
    assign bus.stall     = stall;
    assign bus.issue_ack = issue_ack;

    // The count is the number of cycles still to stall, so fixed latency L loads L-1
    // (L=1 leaves no entry); all-ones is kept as the wait-for-done marker.
    assign load_val = (bus.issue_lat == LAT_V) ? LAT_V : bus.issue_lat - 1'b1;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic ld, dn;
        assign ld = issue_ack && bus.issue_rd == REG_W'(r) && bus.issue_lat != '0;
        assign dn = bus.done_valid && bus.done_rd == REG_W'(r);
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .CLK      (CLK),
            .RST      (RST),
            .flush    (bus.flush),
            .load     (ld),
            .done     (dn),
            .load_val (load_val),
            .cnt      (cnt[r])
        );
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: vector table, directed corner sequences, random vs model.
module tb_forward_scoreboard;
    import cpu_types_pkg::*;

    localparam int unsigned REG_W = 5;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned NFWD  = 2;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned SEL_W = 2;
    localparam logic [LAT_W-1:0] LVAR = LAT_W'(LAT_VAR);

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;

    forward_scoreboard_if #(.REG_W(REG_W), .NSRC(NSRC), .NFWD(NFWD), .LAT_W(LAT_W), .SEL_W(SEL_W)) bus ();

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    forward_scoreboard #(.REG_W(REG_W), .NSRC(NSRC), .NFWD(NFWD), .LAT_W(LAT_W), .SEL_W(SEL_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] src;
        logic [1:0] regwr;
        logic [9:0] wsel;
        logic [3:0] exp_sel;
    } fvec_t;

    fvec_t vt [7];

    int unsigned ready_at [32];
    bit          var_wait [32];
    int unsigned cyc;
    int unsigned model_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.src_addr    = '0;
        bus.fwd_regwr   = '0;
        bus.fwd_wsel    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_lat   = '0;
        bus.done_valid  = 1'b0;
        bus.done_rd     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic issue(input int rd, input logic [LAT_W-1:0] lat);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'(rd);
        bus.issue_lat   = lat;
    endtask

    function automatic bit pend(input logic [4:0] r);
        return r != 0 && (var_wait[r] || cyc < ready_at[r]);
    endfunction

    initial begin
        logic [4:0] s;
        logic [3:0] e_sel;
        logic [1:0] sel;
        logic       e_stall;
        logic       e_ack;

        vt[0] = '{src: {5'd8, 5'd8},  regwr: 2'b11, wsel: {5'd8, 5'd8},  exp_sel: {2'd1, 2'd1}};
        vt[1] = '{src: {5'd8, 5'd8},  regwr: 2'b10, wsel: {5'd8, 5'd8},  exp_sel: {2'd2, 2'd2}};
        vt[2] = '{src: {5'd8, 5'd8},  regwr: 2'b11, wsel: {5'd3, 5'd7},  exp_sel: {2'd0, 2'd0}};
        vt[3] = '{src: {5'd9, 5'd10}, regwr: 2'b11, wsel: {5'd10, 5'd9}, exp_sel: {2'd1, 2'd2}};
        vt[4] = '{src: {5'd0, 5'd0},  regwr: 2'b11, wsel: {5'd0, 5'd0},  exp_sel: {2'd0, 2'd0}};
        vt[5] = '{src: {5'd0, 5'd5},  regwr: 2'b01, wsel: {5'd1, 5'd5},  exp_sel: {2'd0, 2'd1}};
        vt[6] = '{src: {5'd5, 5'd5},  regwr: 2'b00, wsel: {5'd5, 5'd5},  exp_sel: {2'd0, 2'd0}};

        RST = 1'b1;
        idle();
        #12;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_fwd_sel", 32'(bus.forward_sel), 32'd0);
        check("rst_ack", 32'(bus.issue_ack), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge CLK) RST = 1'b0;
        tick();

        for (int t = 0; t < 7; t++) begin
            bus.src_addr  = vt[t].src;
            bus.fwd_regwr = vt[t].regwr;
            bus.fwd_wsel  = vt[t].wsel;
            #1;
            check($sformatf("fwd_vec%0d", t), 32'(bus.forward_sel), 32'(vt[t].exp_sel));
            check($sformatf("fwd_vec%0d_stall", t), 32'(bus.stall), 32'd0);
            tick();
        end

        // Fixed latency 3: two stall cycles, then forward from stage 0.
        idle(); issue(4, 3'd3); #1;
        check("fix_issue_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        idle(); bus.src_addr = {5'd0, 5'd4}; issue(7, 3'd3); #1;
        check("fix_stall1", 32'(bus.stall), 32'd1);
        check("fix_blocked_ack", 32'(bus.issue_ack), 32'd0);
        tick();
        bus.issue_valid = 1'b0; #1;
        check("fix_stall2", 32'(bus.stall), 32'd1);
        tick();
        bus.fwd_regwr = 2'b01; bus.fwd_wsel = {5'd0, 5'd4}; #1;
        check("fix_release", 32'(bus.stall), 32'd0);
        check("fix_fwd_sel", 32'(bus.forward_sel), 32'({2'd0, 2'd1}));
`ifdef FWD_STALL_CNT_EN
        check("fix_stall_cnt", stall_cnt, 32'd2);
`endif
        bus.src_addr = {5'd7, 5'd4}; #1;
        check("blocked_issue_no_entry", 32'(bus.stall), 32'd0);
        tick();

        // Variable latency held until done, released the cycle after.
        idle(); issue(6, LVAR); #1;
        check("var_issue_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        idle(); bus.src_addr = {5'd0, 5'd6};
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("var_hold%0d", c), 32'(bus.stall), 32'd1);
            tick();
        end
        bus.done_valid = 1'b1; bus.done_rd = 5'd6; #1;
        check("var_done_cycle", 32'(bus.stall), 32'd1);
        tick();
        idle(); bus.src_addr = {5'd0, 5'd6}; #1;
        check("var_release", 32'(bus.stall), 32'd0);
        tick();
        idle(); issue(6, LVAR); tick();
        idle(); issue(6, LVAR); bus.done_valid = 1'b1; bus.done_rd = 5'd6; #1;
        check("issue_done_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        idle(); bus.src_addr = {5'd6, 5'd0}; #1;
        check("issue_beats_done", 32'(bus.stall), 32'd1);
        tick();
        idle(); bus.done_valid = 1'b1; bus.done_rd = 5'd6; tick();

        // Flush clears everything; flush beats a same-cycle issue.
        idle(); issue(3, LVAR); tick();
        idle(); issue(5, LVAR); tick();
        idle(); bus.src_addr = {5'd5, 5'd3}; #1;
        check("flush_pre", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1; tick();
        idle(); bus.src_addr = {5'd5, 5'd3}; #1;
        check("flush_clear", 32'(bus.stall), 32'd0);
        bus.src_addr = '0; issue(9, LVAR); bus.flush = 1'b1; tick();
        idle(); bus.src_addr = {5'd0, 5'd9}; #1;
        check("flush_beats_issue", 32'(bus.stall), 32'd0);
        tick();

        // Register 0 never pending nor forwarded.
        idle(); issue(0, 3'd3); tick();
        idle(); bus.fwd_regwr = 2'b01; #1;
        check("r0_stall", 32'(bus.stall), 32'd0);
        check("r0_fwd_sel", 32'(bus.forward_sel), 32'd0);
        tick();

        // Asynchronous reset mid-stall.
        idle(); issue(2, LVAR); tick();
        idle(); bus.src_addr = {5'd0, 5'd2}; #1;
        check("rst_mid_pre", 32'(bus.stall), 32'd1);
        tick(); tick();
        #2; RST = 1'b1; #1;
        check("rst_mid_stall", 32'(bus.stall), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("rst_mid_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge CLK) RST = 1'b0;
        tick();

        // Random traffic against a cycle-count model.
        for (int r = 0; r < 32; r++) begin
            ready_at[r] = 0;
            var_wait[r] = 1'b0;
        end
        cyc = 0;
        model_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.src_addr    = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.fwd_regwr   = 2'($urandom_range(3));
            bus.fwd_wsel    = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.issue_valid = ($urandom_range(2) == 0);
            bus.issue_rd    = 5'($urandom_range(7));
            bus.issue_lat   = 3'($urandom_range(7));
            bus.done_valid  = ($urandom_range(5) == 0);
            bus.done_rd     = 5'($urandom_range(7));
            bus.flush       = ($urandom_range(39) == 0);
            #1;
            e_stall = 1'b0;
            e_sel   = '0;
            for (int i = 0; i < 2; i++) begin
                s = bus.src_addr[i*5 +: 5];
                if (pend(s)) e_stall = 1'b1;
                sel = 2'd0;
                for (int k = 1; k >= 0; k--)
                    if (s != 0 && bus.fwd_regwr[k] && bus.fwd_wsel[k*5 +: 5] == s) sel = 2'(k + 1);
                e_sel[i*2 +: 2] = sel;
            end
            e_ack = bus.issue_valid && !e_stall;
            check($sformatf("rnd%0d_sel", c), 32'(bus.forward_sel), 32'(e_sel));
            check($sformatf("rnd%0d_stall", c), 32'(bus.stall), 32'(e_stall));
            check($sformatf("rnd%0d_ack", c), 32'(bus.issue_ack), 32'(e_ack));
`ifdef FWD_STALL_CNT_EN
            check($sformatf("rnd%0d_stall_cnt", c), stall_cnt, model_cnt);
`endif
            if (bus.flush) begin
                for (int r = 0; r < 32; r++) begin
                    ready_at[r] = 0;
                    var_wait[r] = 1'b0;
                end
            end else begin
                if (bus.done_valid) begin
                    var_wait[bus.done_rd] = 1'b0;
                    ready_at[bus.done_rd] = 0;
                end
                if (e_ack && bus.issue_rd != 0 && bus.issue_lat != 0) begin
                    if (bus.issue_lat == LVAR) begin
                        var_wait[bus.issue_rd] = 1'b1;
                    end else begin
                        var_wait[bus.issue_rd] = 1'b0;
                        ready_at[bus.issue_rd] = cyc + 32'(bus.issue_lat);
                    end
                end
            end
            if (e_stall) model_cnt++;
            cyc++;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
